// File: rtl/fft_power_peak_pkg.sv
// Shared field positions and widths for the FFT power/peak block.
package fft_power_peak_pkg;

    localparam int TDATA_HALF_W    = 16;
    localparam int TUSER_INDEX_LSB = 0;
    localparam int TUSER_EXP_LSB   = 16;
    localparam int TUSER_EXP_MSB   = 20;
    localparam int BLK_EXP_W       = TUSER_EXP_MSB - TUSER_EXP_LSB + 1;
    localparam int PWR_EXP_W       = 6;

    function automatic int pwr_width(input int in_width);
        return 2 * in_width;
    endfunction

endpackage

// File: rtl/fft_power_peak_tracker.sv
// Per-frame peak search, frame-length check and report register on the power stream.
module fft_power_peak_tracker
    import fft_power_peak_pkg::*;
#(
    parameter int LOG2_FFT_LEN  = 11,
    parameter int PW            = 24,
    parameter int PEAK_MIN_BIN  = 1,
    parameter int HALF_SPECTRUM = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clken,
    input  logic                    i_vld,
    input  logic                    i_last,
    input  logic [PW-1:0]           i_pwr,
    input  logic [LOG2_FFT_LEN-1:0] i_index,
    input  logic [PWR_EXP_W-1:0]    i_exp,
    output logic                    o_peak_vld,
    output logic [LOG2_FFT_LEN-1:0] o_peak_index,
    output logic [PW-1:0]           o_peak_pwr,
    output logic [PWR_EXP_W-1:0]    o_peak_exp,
    output logic                    o_frame_err
);

    localparam int IW = LOG2_FFT_LEN;
    localparam logic [IW-1:0] MIN_IDX  = IW'(PEAK_MIN_BIN);
    localparam logic [IW-1:0] HALF_IDX = IW'(1 << (IW - 1));
    localparam logic [IW-1:0] LAST_CNT = '1;

    logic            first_q, first_d;
    logic [IW-1:0]   best_idx_q, best_idx_d;
    logic [PW-1:0]   best_pwr_q, best_pwr_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            rpt_vld_q, rpt_vld_d;
    logic [IW-1:0]   rpt_idx_q, rpt_idx_d;
    logic [PW-1:0]   rpt_pwr_q, rpt_pwr_d;
    logic [PWR_EXP_W-1:0] rpt_exp_q, rpt_exp_d;
    logic            rpt_err_q, rpt_err_d;

    logic            eligible, take;
    logic [IW-1:0]   cur_idx;
    logic [PW-1:0]   cur_pwr;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        first_d    = first_q;
        best_idx_d = best_idx_q;
        best_pwr_d = best_pwr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rpt_vld_d  = 1'b0;
        rpt_idx_d  = rpt_idx_q;
        rpt_pwr_d  = rpt_pwr_q;
        rpt_exp_d  = rpt_exp_q;
        rpt_err_d  = 1'b0;

        eligible = (i_index >= MIN_IDX) && ((HALF_SPECTRUM == 0) || (i_index < HALF_IDX));
        // Strict compare on later bins keeps the lowest index on ties.
        take     = i_vld && eligible && (first_q || (i_pwr > best_pwr_q));
        cur_idx  = take ? i_index : best_idx_q;
        cur_pwr  = take ? i_pwr   : best_pwr_q;

        if (i_vld) begin
            if (i_last) begin
                rpt_vld_d  = 1'b1;
                rpt_idx_d  = cur_idx;
                rpt_pwr_d  = cur_pwr;
                rpt_exp_d  = i_exp;
                rpt_err_d  = err_q || (cnt_q != LAST_CNT);
                err_d      = 1'b0;
                cnt_d      = '0;
                first_d    = 1'b1;
                best_idx_d = '0;
                best_pwr_d = '0;
            end else begin
                first_d    = first_q && !eligible;
                best_idx_d = cur_idx;
                best_pwr_d = cur_pwr;
                if (cnt_q == LAST_CNT) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            first_q    <= 1'b1;
            best_idx_q <= '0;
            best_pwr_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rpt_vld_q  <= 1'b0;
            rpt_idx_q  <= '0;
            rpt_pwr_q  <= '0;
            rpt_exp_q  <= '0;
            rpt_err_q  <= 1'b0;
        end else if (i_clken) begin
            first_q    <= first_d;
            best_idx_q <= best_idx_d;
            best_pwr_q <= best_pwr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rpt_vld_q  <= rpt_vld_d;
            rpt_idx_q  <= rpt_idx_d;
            rpt_pwr_q  <= rpt_pwr_d;
            rpt_exp_q  <= rpt_exp_d;
            rpt_err_q  <= rpt_err_d;
        end
    end

    assign o_peak_vld   = rpt_vld_q;
    assign o_peak_index = rpt_idx_q;
    assign o_peak_pwr   = rpt_pwr_q;
    assign o_peak_exp   = rpt_exp_q;
    assign o_frame_err  = rpt_err_q;

endmodule

// File: rtl/fft_power_peak.sv
// Three-stage power pipeline (register, square, sum) feeding the frame peak tracker.
module fft_power_peak
    import fft_power_peak_pkg::*;
#(
    parameter int LOG2_FFT_LEN  = 11,
    parameter int IN_WIDTH      = 12,
    parameter int PEAK_MIN_BIN  = 1,
    parameter int HALF_SPECTRUM = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_clken,
    input  logic                           i_axi4s_data_tvalid,
    input  logic [31:0]                    i_axi4s_data_tdata,
    input  logic                           i_axi4s_data_tlast,
    input  logic [23:0]                    i_axi4s_data_tuser,
    output logic                           o_pwr_tvalid,
    output logic [pwr_width(IN_WIDTH)-1:0] o_pwr_tdata,
    output logic                           o_pwr_tlast,
    output logic [LOG2_FFT_LEN-1:0]        o_pwr_index,
    output logic [PWR_EXP_W-1:0]           o_pwr_exp,
    output logic                           o_peak_vld,
    output logic [LOG2_FFT_LEN-1:0]        o_peak_index,
    output logic [pwr_width(IN_WIDTH)-1:0] o_peak_pwr,
    output logic [PWR_EXP_W-1:0]           o_peak_exp,
    output logic                           o_frame_err
);

    localparam int PW = pwr_width(IN_WIDTH);
    localparam int IW = LOG2_FFT_LEN;

    logic                        s1_vld_q, s2_vld_q, s3_vld_q;
    logic                        s1_last_q, s2_last_q, s3_last_q;
    logic signed [IN_WIDTH-1:0]  s1_re_q, s1_im_q;
    logic [IW-1:0]               s1_idx_q, s2_idx_q, s3_idx_q;
    logic [BLK_EXP_W-1:0]        s1_exp_q, s2_exp_q;
    logic [PWR_EXP_W-1:0]        s3_exp_q, s3_exp_d;
    logic signed [PW-1:0]        s2_pr_q, s2_pr_d, s2_pi_q, s2_pi_d;
    logic [PW-1:0]               s3_pwr_q, s3_pwr_d;
    logic                        unused_bits;

    // Upper tdata/tuser bits are sign extension or reserved.
    assign unused_bits = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

    // Each square of a signed IN_WIDTH value fits in PW signed bits; the sum fits PW unsigned.
    always_comb begin
        s2_pr_d  = PW'(s1_re_q) * PW'(s1_re_q);
        s2_pi_d  = PW'(s1_im_q) * PW'(s1_im_q);
        s3_pwr_d = $unsigned(s2_pr_q) + $unsigned(s2_pi_q);
        s3_exp_d = {s2_exp_q, 1'b0};
    end

    // NOTE: sequential state uses non-blocking assignments so all stages advance together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s2_last_q <= 1'b0;
            s3_last_q <= 1'b0;
            s1_re_q   <= '0;
            s1_im_q   <= '0;
            s1_idx_q  <= '0;
            s2_idx_q  <= '0;
            s3_idx_q  <= '0;
            s1_exp_q  <= '0;
            s2_exp_q  <= '0;
            s3_exp_q  <= '0;
            s2_pr_q   <= '0;
            s2_pi_q   <= '0;
            s3_pwr_q  <= '0;
        end else if (i_clken) begin
            s1_vld_q  <= i_axi4s_data_tvalid;
            s1_last_q <= i_axi4s_data_tvalid && i_axi4s_data_tlast;
            if (i_axi4s_data_tvalid) begin
                s1_re_q  <= i_axi4s_data_tdata[IN_WIDTH-1:0];
                s1_im_q  <= i_axi4s_data_tdata[TDATA_HALF_W +: IN_WIDTH];
                s1_idx_q <= i_axi4s_data_tuser[TUSER_INDEX_LSB +: IW];
                s1_exp_q <= i_axi4s_data_tuser[TUSER_EXP_MSB:TUSER_EXP_LSB];
            end
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            if (s1_vld_q) begin
                s2_pr_q  <= s2_pr_d;
                s2_pi_q  <= s2_pi_d;
                s2_idx_q <= s1_idx_q;
                s2_exp_q <= s1_exp_q;
            end
            s3_vld_q  <= s2_vld_q;
            s3_last_q <= s2_last_q;
            if (s2_vld_q) begin
                s3_pwr_q <= s3_pwr_d;
                s3_idx_q <= s2_idx_q;
                s3_exp_q <= s3_exp_d;
            end
        end
    end

    assign o_pwr_tvalid = s3_vld_q;
    assign o_pwr_tdata  = s3_pwr_q;
    assign o_pwr_tlast  = s3_last_q;
    assign o_pwr_index  = s3_idx_q;
    assign o_pwr_exp    = s3_exp_q;

    fft_power_peak_tracker #(
        .LOG2_FFT_LEN  (LOG2_FFT_LEN),
        .PW            (PW),
        .PEAK_MIN_BIN  (PEAK_MIN_BIN),
        .HALF_SPECTRUM (HALF_SPECTRUM)
    ) u_tracker (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_clken      (i_clken),
        .i_vld        (s3_vld_q),
        .i_last       (s3_last_q),
        .i_pwr        (s3_pwr_q),
        .i_index      (s3_idx_q),
        .i_exp        (s3_exp_q),
        .o_peak_vld   (o_peak_vld),
        .o_peak_index (o_peak_index),
        .o_peak_pwr   (o_peak_pwr),
        .o_peak_exp   (o_peak_exp),
        .o_frame_err  (o_frame_err)
    );

endmodule

// File: tb/tb_fft_power_peak.sv
// Scoreboard bench: two instances (half / full spectrum search) on one N=8 input stream.
module tb_fft_power_peak;

    localparam int L  = 3;
    localparam int N  = 8;
    localparam int W  = 12;
    localparam int PW = 2 * W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clken = 1'b1;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [31:0] tdata = '0;
    logic [23:0] tuser = '0;

    logic          pwr_vld[2], pwr_last[2], pk_vld[2], pk_err[2];
    logic [PW-1:0] pwr_data[2], pk_pwr[2];
    logic [L-1:0]  pwr_idx[2], pk_idx[2];
    logic [5:0]    pwr_exp[2], pk_exp[2];

    typedef struct {
        longint pwr;
        int     idx;
        int     exp;
        bit     last;
        int     at;
    } pwr_item_t;

    typedef struct {
        longint pwr;
        int     idx;
        int     exp;
        bit     err;
        int     at;
    } peak_item_t;

    typedef struct {
        int     idx;
        longint pwr;
    } bin_t;

    pwr_item_t  pwr_q[2][$];
    peak_item_t peak_q[2][$];
    bin_t       frame[$];

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    bit edge_en = 1'b0;
    bit toggle  = 1'b0;

    always #5 clk = ~clk;

    fft_power_peak #(
        .LOG2_FFT_LEN(L), .IN_WIDTH(W), .PEAK_MIN_BIN(1), .HALF_SPECTRUM(1)
    ) u_half (
        .i_clk(clk), .i_rst(rst), .i_clken(clken),
        .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
        .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
        .o_pwr_tvalid(pwr_vld[0]), .o_pwr_tdata(pwr_data[0]), .o_pwr_tlast(pwr_last[0]),
        .o_pwr_index(pwr_idx[0]), .o_pwr_exp(pwr_exp[0]),
        .o_peak_vld(pk_vld[0]), .o_peak_index(pk_idx[0]), .o_peak_pwr(pk_pwr[0]),
        .o_peak_exp(pk_exp[0]), .o_frame_err(pk_err[0])
    );

    fft_power_peak #(
        .LOG2_FFT_LEN(L), .IN_WIDTH(W), .PEAK_MIN_BIN(1), .HALF_SPECTRUM(0)
    ) u_full (
        .i_clk(clk), .i_rst(rst), .i_clken(clken),
        .i_axi4s_data_tvalid(tvalid), .i_axi4s_data_tdata(tdata),
        .i_axi4s_data_tlast(tlast), .i_axi4s_data_tuser(tuser),
        .o_pwr_tvalid(pwr_vld[1]), .o_pwr_tdata(pwr_data[1]), .o_pwr_tlast(pwr_last[1]),
        .o_pwr_index(pwr_idx[1]), .o_pwr_exp(pwr_exp[1]),
        .o_peak_vld(pk_vld[1]), .o_peak_index(pk_idx[1]), .o_peak_pwr(pk_pwr[1]),
        .o_peak_exp(pk_exp[1]), .o_frame_err(pk_err[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Enabled-edge counter gives the timing reference for latency checks.
    always @(posedge clk) begin
        edge_en = clken && !rst;
        if (edge_en) ecnt++;
    end

    task automatic mon(input int k);
        pwr_item_t  pe;
        peak_item_t ke;
        if (pwr_vld[k] === 1'b1) begin
            check($sformatf("u%0d pwr_expected", k), 64'(pwr_q[k].size() != 0), 1);
            if (pwr_q[k].size() != 0) begin
                pe = pwr_q[k].pop_front();
                check($sformatf("u%0d pwr_data", k),  pwr_data[k], pe.pwr);
                check($sformatf("u%0d pwr_index", k), pwr_idx[k],  pe.idx);
                check($sformatf("u%0d pwr_exp", k),   pwr_exp[k],  pe.exp);
                check($sformatf("u%0d pwr_last", k),  pwr_last[k], pe.last);
                check($sformatf("u%0d pwr_latency", k), ecnt, pe.at);
            end
        end
        if (pk_vld[k] === 1'b1) begin
            check($sformatf("u%0d peak_expected", k), 64'(peak_q[k].size() != 0), 1);
            if (peak_q[k].size() != 0) begin
                ke = peak_q[k].pop_front();
                check($sformatf("u%0d peak_index", k), pk_idx[k], ke.idx);
                check($sformatf("u%0d peak_pwr", k),   pk_pwr[k], ke.pwr);
                check($sformatf("u%0d peak_exp", k),   pk_exp[k], ke.exp);
                check($sformatf("u%0d frame_err", k),  pk_err[k], ke.err);
                check($sformatf("u%0d peak_latency", k), ecnt, ke.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (edge_en) begin
            mon(0);
            mon(1);
        end
    end

    task automatic finish_frame(input int e, input int bexp);
        peak_item_t ke;
        bit         found;
        bit         elig;
        for (int k = 0; k < 2; k++) begin
            found  = 1'b0;
            ke.idx = 0;
            ke.pwr = 0;
            foreach (frame[j]) begin
                elig = (frame[j].idx >= 1) && ((k == 1) || (frame[j].idx < N / 2));
                if (elig && (!found || frame[j].pwr > ke.pwr)) begin
                    ke.idx = frame[j].idx;
                    ke.pwr = frame[j].pwr;
                    found  = 1'b1;
                end
            end
            ke.exp = 2 * bexp;
            ke.err = (frame.size() != N);
            ke.at  = e + 3;
            peak_q[k].push_back(ke);
        end
        frame.delete();
    endtask

    task automatic send(input int re, input int im, input int idx, input int bexp, input bit last);
        pwr_item_t pe;
        bin_t      b;
        int        e;
        tvalid = 1'b1;
        tlast  = last;
        tdata  = {16'(im), 16'(re)};
        tuser  = {3'b000, 5'(bexp), 16'(idx)};
        if (toggle) begin
            clken = 1'b0;
            @(posedge clk);
            #1;
            clken = 1'b1;
        end
        @(posedge clk);
        #1;
        e       = ecnt;
        pe.pwr  = longint'(re) * re + longint'(im) * im;
        pe.idx  = idx;
        pe.exp  = 2 * bexp;
        pe.last = last;
        pe.at   = e + 2;
        pwr_q[0].push_back(pe);
        pwr_q[1].push_back(pe);
        b.idx = idx;
        b.pwr = pe.pwr;
        frame.push_back(b);
        if (last) finish_frame(e, bexp);
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pwr_q[k].delete();
            peak_q[k].delete();
        end
        frame.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d rst pwr_tvalid", k), pwr_vld[k],  0);
            check($sformatf("u%0d rst pwr_tdata", k),  pwr_data[k], 0);
            check($sformatf("u%0d rst pwr_tlast", k),  pwr_last[k], 0);
            check($sformatf("u%0d rst pwr_index", k),  pwr_idx[k],  0);
            check($sformatf("u%0d rst pwr_exp", k),    pwr_exp[k],  0);
            check($sformatf("u%0d rst peak_vld", k),   pk_vld[k],   0);
            check($sformatf("u%0d rst peak_index", k), pk_idx[k],   0);
            check($sformatf("u%0d rst peak_pwr", k),   pk_pwr[k],   0);
            check($sformatf("u%0d rst peak_exp", k),   pk_exp[k],   0);
            check($sformatf("u%0d rst frame_err", k),  pk_err[k],   0);
        end
        @(posedge clk);
        #1;

        // Single tone at bin 5 (3,-4), with a bubble mid-frame.
        for (int i = 0; i < N; i++) begin
            send((i == 5) ? 3 : 0, (i == 5) ? -4 : 0, i, 0, i == N - 1);
            if (i == 2) idle(1);
        end
        idle(6);

        // Tie at bins 1 and 2, then back-to-back a frame with a large DC and bin 6.
        for (int i = 0; i < N; i++) send((i == 1 || i == 2) ? 100 : 0, 0, i, 0, i == N - 1);
        for (int i = 0; i < N; i++) send((i == 0) ? 2047 : ((i == 6) ? 10 : 0), 0, i, 0, i == N - 1);
        idle(6);

        // Exponent 7 and full-scale negative input on bin 2.
        for (int i = 0; i < N; i++) send((i == 2) ? -2048 : i, (i == 2) ? -2048 : 0, i, 7, i == N - 1);
        idle(6);

        // Short frame (tlast on the 6th bin), then a correct frame.
        for (int i = 0; i < 6; i++) send(i * 3, 1, i, 2, i == 5);
        for (int i = 0; i < N; i++) send((i == 3) ? -7 : 1, (i == 3) ? 5 : 0, i, 1, i == N - 1);
        idle(6);

        // Frame with no eligible bin, then an over-long frame wrapping the counter.
        send(50, 0, 0, 3, 1'b1);
        for (int i = 0; i < N + 2; i++) send((i == N + 1) ? 3 : i + 1, 0, i % N, 4, i == N + 1);
        idle(6);

        // Partial frame discarded by a one-cycle reset, then a full frame.
        for (int i = 0; i < 3; i++) send(500, 500, i, 5, 1'b0);
        do_reset();
        for (int i = 0; i < N; i++) send(i * 10, -i, i, 6, i == N - 1);
        idle(6);

        // Two back-to-back frames with clock enable toggling every other cycle.
        toggle = 1'b1;
        for (int i = 0; i < N; i++) send((i == 7) ? 900 : i, (i == 3) ? -30 : 0, i, 9, i == N - 1);
        for (int i = 0; i < N; i++) send(-i * 20, i, i, 31, i == N - 1);
        toggle = 1'b0;
        idle(10);

        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d pwr_drained", k),  pwr_q[k].size(),  0);
            check($sformatf("u%0d peak_drained", k), peak_q[k].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_power_peak.md
# fft_power_peak

Streaming power-spectrum and peak-bin detector directly downstream of the FFT core's AXI4-Stream output. Converts each complex bin to power re²+im², forwards the power stream with bin index, frame boundary and the frame's block exponent, and reports the strongest bin of every frame. Has no backpressure path, because the FFT output has no tready; it must accept one bin per enabled cycle.

## Interface
- LOG2_FFT_LEN, 11: log2 of frame length N; range 3..16.
- IN_WIDTH, 12: signed width of re/im carried in each 16-bit tdata half.
- PEAK_MIN_BIN, 1: lowest bin index eligible for the peak search; 1 excludes DC.
- HALF_SPECTRUM, 1: 1 limits the peak search to bins < N/2; 0 searches all bins.
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_clken  in  1  clock enable; all state, including the pipeline, holds when low.
- i_axi4s_data_tvalid  in  1  bin valid.
- i_axi4s_data_tdata  in  32  re in [IN_WIDTH-1:0], im in [16+IN_WIDTH-1:16]; upper bits of each half are sign extension.
- i_axi4s_data_tlast  in  1  last bin of frame.
- i_axi4s_data_tuser  in  24  bin index in [LOG2_FFT_LEN-1:0], blk_exp in [20:16].
- o_pwr_tvalid  out  1  power sample valid.
- o_pwr_tdata  out  2*IN_WIDTH  unsigned re²+im², mantissa.
- o_pwr_tlast  out  1  last bin of frame.
- o_pwr_index  out  LOG2_FFT_LEN  bin index.
- o_pwr_exp  out  6  power exponent = 2*blk_exp.
- o_peak_vld  out  1  one-cycle pulse; the fields below are valid.
- o_peak_index  out  LOG2_FFT_LEN  index of the strongest eligible bin.
- o_peak_pwr  out  2*IN_WIDTH  power of that bin.
- o_peak_exp  out  6  frame exponent.
- o_frame_err  out  1  qualified by o_peak_vld; the frame length was not N.

## Operation
- Power is computed as re*re + im*im with signed IN_WIDTH operands. Maximum power is 2·2^(2·IN_WIDTH−2), so it fits in 2*IN_WIDTH unsigned bits with no saturation.
- Block exponent is captured on every bin and re-registered alongside the data. Only the value on the tlast bin goes to o_peak_exp.
- Peak tracker works on the stage-3 output with a flag `first` that is set after reset and after every tlast.
  - A bin is eligible when index ≥ PEAK_MIN_BIN and, if HALF_SPECTRUM=1, index < N/2.
  - The first eligible bin of a frame loads the tracker unconditionally.
  - After that, the tracker updates only on strictly greater power, so ties keep the lower index.
  - If a frame has no eligible bin, the report carries index 0 and power 0.
- Frame counter `cnt` increments per accepted bin and clears on tlast.
  - If tlast arrives with cnt ≠ N−1, the error latch is set.
  - If cnt = N−1 and tlast is absent, the error latch is set and `cnt` wraps to 0, but the frame continues until tlast.
  - The error latch clears when the report is issued.
- The report is issued on the cycle after the tlast bin leaves stage 3. o_frame_err is asserted in the same cycle as o_peak_vld.
- Reset mid-frame discards the partial frame: no report, and the pipeline valids clear.

## Timing
- Pipeline: S1 input register, S2 two products (DSP), S3 sum. o_pwr_* appear 3 enabled cycles after input acceptance.
- o_peak_vld is asserted 4 enabled cycles after the tlast input.
- Back-to-back frames with no idle cycle are supported. The report of frame k coincides with the first or second bin of frame k+1 on o_pwr.
- Reset values:
  - all valids, o_pwr_tlast and o_frame_err are 0;
  - o_pwr_tdata, o_pwr_index, o_pwr_exp and all o_peak_* data are 0;
  - `first` is 1 and `cnt` is 0.
- i_clken low freezes every register; o_peak_vld is held, not re-pulsed. Consumers qualify outputs with i_clken.
- tvalid low produces bubbles that propagate unchanged; there are no gaps in the index stream beyond those given on input.

## Structure
- Shared package/header holds:
  - the tuser field positions: index LSB 0, blk_exp 20:16;
  - the tdata half width of 16;
  - the power width function 2*IN_WIDTH.
- One natural sub-module, fft_power_peak_tracker: the eligibility check, compare/update, error latch and report register, driven by the S3 outputs.

## Test plan
- LOG2_FFT_LEN=3, a single bin index 5 at re=3, im=−4, all others 0 → o_pwr_tdata=25 at index 5, 3 cycles later. o_peak_index=5, o_peak_pwr=25, o_frame_err=0.
- Bins 1 and 2 both at re=100, im=0 → peak index 1 (tie keeps the lower index), power 10000.
- DC bin re=2047 plus bin 6 at re=10, HALF_SPECTRUM=1 → peak index 3 or lower (bin 6 excluded, DC excluded); with HALF_SPECTRUM=0 the peak is bin 6, power 100.
- blk_exp=7 on all bins → o_pwr_exp=14 and o_peak_exp=14. re=im=−2048 → power 8388608 with no overflow.
- tlast at the 6th bin → report on schedule with o_frame_err=1. The next correct frame reports o_frame_err=0.
- i_rst asserted for one cycle mid-frame, then a full frame → exactly one report, for the new frame only. Two back-to-back frames with i_clken toggling 50% → two reports, correct values.
